// File: rtl/varredura_matriz_pkg.sv
// Shared types and constants for the 5x7 LED matrix scan driver.
//   NUM_COLS / NUM_ROWS : fixed matrix geometry
//   col_idx_t           : 3-bit column index (0..4 in use)
//   row_map_t           : 7-bit row bitmap, bit i = row i
//   next_col()          : column successor, wraps 4 -> 0 and recovers 5..7 to 0
package matriz_pkg;

    localparam int unsigned NUM_COLS = 5;
    localparam int unsigned NUM_ROWS = 7;

    typedef logic [2:0]          col_idx_t;
    typedef logic [NUM_ROWS-1:0] row_map_t;

    localparam col_idx_t MAX_COL = 3'd4;

    // Any index at or beyond the last column goes back to 0, so a corrupted
    // value (5..7) self-heals on the next tick.
    function automatic col_idx_t next_col(input col_idx_t col);
        return (col >= MAX_COL) ? '0 : col + 3'd1;
    endfunction

endpackage

// File: rtl/varredura_matriz_if.sv
// Bundle between the bitmap source and the scan driver.
//   enable         : 1 = matrix driven, 0 = blanked
//   mapa0..mapa4   : row bitmap per column
//   l0..l6         : row lines, 1 = lit
//   c0..c4         : column lines, active-low
//   contador       : current column index
//   tick           : one-cycle column-advance pulse
// master = bitmap source side, slave = scan driver side.
interface varredura_matriz_if;
    import matriz_pkg::*;

    logic     enable;
    row_map_t mapa0, mapa1, mapa2, mapa3, mapa4;
    logic     l0, l1, l2, l3, l4, l5, l6;
    logic     c0, c1, c2, c3, c4;
    col_idx_t contador;
    logic     tick;

    modport master (
        output enable, mapa0, mapa1, mapa2, mapa3, mapa4,
        input  l0, l1, l2, l3, l4, l5, l6, c0, c1, c2, c3, c4, contador, tick
    );

    modport slave (
        input  enable, mapa0, mapa1, mapa2, mapa3, mapa4,
        output l0, l1, l2, l3, l4, l5, l6, c0, c1, c2, c3, c4, contador, tick
    );

endinterface

// File: rtl/varredura_matriz_gerador_tick.sv
// Free-running prescaler producing a one-cycle tick every 2^DIV_BITS clocks.
//   clock_in : system clock
//   reset    : synchronous, active-high; clears the prescaler and masks tick
//   tick     : high while the prescaler holds all-ones and reset is low
module gerador_tick #(
    parameter int unsigned DIV_BITS = 16
) (
    input  logic clock_in,
    input  logic reset,
    output logic tick
);

    logic [DIV_BITS-1:0] prescaler_q;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            prescaler_q <= '0;
        end else begin
            prescaler_q <= prescaler_q + DIV_BITS'(1);
        end
    end

    // Masking with reset makes reset win over a coincident terminal count.
    assign tick = (&prescaler_q) && !reset;

endmodule

// File: rtl/varredura_matriz.sv
// Multiplexed scan driver for a 5-column x 7-row LED matrix.
//   clock_in : system clock, all state on rising edge
//   reset    : synchronous, active-high
//   bus      : slave side of varredura_matriz_if (enable, bitmaps in;
//              row/column lines, column index and tick out)
// The column index advances on each prescaler tick; rows show the bitmap of
// the active column. Decode is combinational so bitmap/enable changes show
// in the same cycle.
module varredura_matriz
    import matriz_pkg::*;
#(
    parameter int unsigned DIV_BITS = 16
) (
    input  logic                clock_in,
    input  logic                reset,
    varredura_matriz_if.slave   bus
);

    logic                tick;
    col_idx_t            contador_q;
    logic [NUM_COLS-1:0] col_n;
    row_map_t            rows;

    gerador_tick #(
        .DIV_BITS (DIV_BITS)
    ) u_gerador_tick (
        .clock_in (clock_in),
        .reset    (reset),
        .tick     (tick)
    );

    always_ff @(posedge clock_in) begin
        if (reset) begin
            contador_q <= '0;
        end else if (tick) begin
            contador_q <= next_col(contador_q);
        end
    end

    // Blanked by default; unreachable indices 5..7 also leave the matrix dark.
    always_comb begin
        col_n = '1;
        rows  = '0;
        if (bus.enable) begin
            unique case (contador_q)
                3'd0: begin col_n[0] = 1'b0; rows = bus.mapa0; end
                3'd1: begin col_n[1] = 1'b0; rows = bus.mapa1; end
                3'd2: begin col_n[2] = 1'b0; rows = bus.mapa2; end
                3'd3: begin col_n[3] = 1'b0; rows = bus.mapa3; end
                3'd4: begin col_n[4] = 1'b0; rows = bus.mapa4; end
                default: begin
                    col_n = '1;
                    rows  = '0;
                end
            endcase
        end
    end

    assign bus.c0 = col_n[0];
    assign bus.c1 = col_n[1];
    assign bus.c2 = col_n[2];
    assign bus.c3 = col_n[3];
    assign bus.c4 = col_n[4];

    assign bus.l0 = rows[0];
    assign bus.l1 = rows[1];
    assign bus.l2 = rows[2];
    assign bus.l3 = rows[3];
    assign bus.l4 = rows[4];
    assign bus.l5 = rows[5];
    assign bus.l6 = rows[6];

    assign bus.contador = contador_q;
    assign bus.tick     = tick;

endmodule

// File: tb/tb_varredura_matriz.sv
// Directed bench for varredura_matriz with DIV_BITS = 2 (tick every 4 clocks).
// A small cycle model (prescaler + column) tracks expected state.
module tb_varredura_matriz;

    localparam int unsigned DIV_BITS = 2;
    localparam int          PERIOD   = 4;

    logic clk;
    logic reset;

    varredura_matriz_if bus ();

    varredura_matriz #(
        .DIV_BITS (DIV_BITS)
    ) dut (
        .clock_in (clk),
        .reset    (reset),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int exp_p   = 0;
    int exp_col = 0;

    logic [4:0] act_c;
    logic [6:0] act_l;
    logic [6:0] maps [5];

    assign act_c = {bus.c4, bus.c3, bus.c2, bus.c1, bus.c0};
    assign act_l = {bus.l6, bus.l5, bus.l4, bus.l3, bus.l2, bus.l1, bus.l0};

    function automatic logic [4:0] exp_c(input int col, input logic en);
        logic [4:0] one;
        one = 5'b00001;
        return en ? ~(one << col) : 5'b11111;
    endfunction

    function automatic logic [6:0] exp_l(input int col, input logic en);
        return en ? maps[col] : 7'h00;
    endfunction

    task automatic drive_maps();
        bus.mapa0 = maps[0];
        bus.mapa1 = maps[1];
        bus.mapa2 = maps[2];
        bus.mapa3 = maps[3];
        bus.mapa4 = maps[4];
    endtask

    // One clock: advance the model at the edge, settle after the falling edge.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            exp_p   = 0;
            exp_col = 0;
        end else begin
            if (exp_p == PERIOD - 1) exp_col = (exp_col == 4) ? 0 : exp_col + 1;
            exp_p = (exp_p + 1) % PERIOD;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.enable = 1'b1;
        maps[0] = 7'h55; maps[1] = 7'h01; maps[2] = 7'h02; maps[3] = 7'h04; maps[4] = 7'h08;
        drive_maps();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if (bus.contador !== 3'd0) begin
            n_fail++; $display("FAIL reset_contador: got %0d want 0", bus.contador);
        end
        n_checks++;
        if (act_c !== 5'b11110) begin
            n_fail++; $display("FAIL reset_cols: got %b want 11110", act_c);
        end
        n_checks++;
        if (act_l !== 7'b1010101) begin
            n_fail++; $display("FAIL reset_rows: got %b want 1010101", act_l);
        end
        n_checks++;
        if (bus.tick !== 1'b0) begin
            n_fail++; $display("FAIL reset_tick: got %b want 0", bus.tick);
        end
        reset = 1'b0;
    endtask

    task automatic test_scan();
        maps[0] = 7'h01; maps[1] = 7'h02; maps[2] = 7'h04; maps[3] = 7'h08; maps[4] = 7'h10;
        drive_maps();
        #1;
        for (int i = 0; i < 6 * PERIOD; i++) begin
            n_checks++;
            if (bus.tick !== (exp_p == PERIOD - 1)) begin
                n_fail++; $display("FAIL scan_tick[%0d]: got %b want %b", i, bus.tick, exp_p == PERIOD - 1);
            end
            n_checks++;
            if (bus.contador !== 3'(exp_col)) begin
                n_fail++; $display("FAIL scan_contador[%0d]: got %0d want %0d", i, bus.contador, exp_col);
            end
            n_checks++;
            if (act_c !== exp_c(exp_col, 1'b1) || act_l !== exp_l(exp_col, 1'b1)) begin
                n_fail++;
                $display("FAIL scan_lines[%0d]: got c=%b l=%b want c=%b l=%b", i, act_c, act_l,
                         exp_c(exp_col, 1'b1), exp_l(exp_col, 1'b1));
            end
            step();
        end
    endtask

    task automatic test_wrap();
        int guard;
        int ticks;
        guard = 0;
        while (!(exp_col == 4 && exp_p == 0) && guard < 40) begin
            step();
            guard++;
        end
        n_checks++;
        if (guard >= 40) begin
            n_fail++; $display("FAIL wrap_reach: column 4 not reached, got %0d want 4", bus.contador);
        end
        ticks = 0;
        for (int i = 0; i < 5 * PERIOD; i++) begin
            if (bus.tick === 1'b1) ticks++;
            n_checks++;
            if (bus.contador > 3'd4 || $countones(~act_c) != 1) begin
                n_fail++; $display("FAIL wrap_onehot[%0d]: got idx=%0d c=%b want idx<5 one low", i, bus.contador, act_c);
            end
            step();
            if (i == PERIOD - 1) begin
                n_checks++;
                if (bus.contador !== 3'd0) begin
                    n_fail++; $display("FAIL wrap_to_zero: got %0d want 0", bus.contador);
                end
            end
        end
        n_checks++;
        if (ticks != 5 || bus.contador !== 3'd4) begin
            n_fail++; $display("FAIL wrap_frame: got ticks=%0d idx=%0d want ticks=5 idx=4", ticks, bus.contador);
        end
    endtask

    task automatic test_enable_blank();
        bus.enable = 1'b0;
        #1;
        n_checks++;
        if (act_c !== 5'b11111 || act_l !== 7'h00) begin
            n_fail++; $display("FAIL blank_now: got c=%b l=%b want c=11111 l=0000000", act_c, act_l);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (bus.contador !== 3'(exp_col) || act_c !== 5'b11111 || act_l !== 7'h00) begin
                n_fail++;
                $display("FAIL blank_run[%0d]: got idx=%0d c=%b l=%b want idx=%0d c=11111 l=0000000", i,
                         bus.contador, act_c, act_l, exp_col);
            end
        end
        bus.enable = 1'b1;
        #1;
        n_checks++;
        if (bus.contador !== 3'(exp_col) || act_c !== exp_c(exp_col, 1'b1) ||
            act_l !== exp_l(exp_col, 1'b1)) begin
            n_fail++;
            $display("FAIL blank_resume: got idx=%0d c=%b l=%b want idx=%0d c=%b l=%b", bus.contador,
                     act_c, act_l, exp_col, exp_c(exp_col, 1'b1), exp_l(exp_col, 1'b1));
        end
    endtask

    task automatic test_live_bitmap();
        int guard;
        guard = 0;
        while (!(exp_col == 2 && exp_p == 0) && guard < 40) begin
            step();
            guard++;
        end
        maps[2] = 7'h7F;
        drive_maps();
        #1;
        n_checks++;
        if (bus.contador !== 3'd2 || act_l !== 7'h7F) begin
            n_fail++; $display("FAIL live_full: got idx=%0d l=%b want idx=2 l=1111111", bus.contador, act_l);
        end
        maps[2] = 7'h00;
        drive_maps();
        #1;
        n_checks++;
        if (act_l !== 7'h00 || bus.contador !== 3'd2 || act_c !== 5'b11011) begin
            n_fail++;
            $display("FAIL live_clear: got idx=%0d c=%b l=%b want idx=2 c=11011 l=0000000", bus.contador,
                     act_c, act_l);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while (!(exp_col == 3 && exp_p == PERIOD - 1) && guard < 40) begin
            step();
            guard++;
        end
        n_checks++;
        if (bus.tick !== 1'b1 || bus.contador !== 3'd3) begin
            n_fail++; $display("FAIL midreset_setup: got tick=%b idx=%0d want tick=1 idx=3", bus.tick, bus.contador);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.tick !== 1'b0) begin
            n_fail++; $display("FAIL midreset_tick_mask: got %b want 0", bus.tick);
        end
        step();
        n_checks++;
        if (bus.contador !== 3'd0 || act_c !== 5'b11110) begin
            n_fail++; $display("FAIL midreset_wins: got idx=%0d c=%b want idx=0 c=11110", bus.contador, act_c);
        end
        reset = 1'b0;
        // Released after the edge: prescaler at 0, so advance lands 4 edges later.
        for (int i = 1; i <= PERIOD; i++) begin
            step();
            n_checks++;
            if (bus.contador !== ((i == PERIOD) ? 3'd1 : 3'd0)) begin
                n_fail++;
                $display("FAIL midreset_resume[%0d]: got %0d want %0d", i, bus.contador, (i == PERIOD) ? 1 : 0);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        bus.enable = 1'b0;
        @(negedge clk);
        test_reset();
        test_scan();
        test_wrap();
        test_enable_blank();
        test_live_bitmap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
